// File: rtl/mc_core.sv
// Multi-cycle core: FETCH/EXEC/MEM sequencer with req/ack handshakes to external
// instruction and data memories, HALT/DONE_PC completion and a saturating cycle counter.
module mc_core #(
    parameter int unsigned D       = 10,
    parameter int unsigned W       = 8,
    parameter int unsigned RW      = 3,
    parameter int unsigned DONE_PC = 354,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          imem_req,
    output logic [D-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic [8:0]    imem_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [W-1:0]  dmem_addr,
    output logic [W-1:0]  dmem_wdata,
    input  logic          dmem_ack,
    input  logic [W-1:0]  dmem_rdata,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);

    localparam int unsigned   NREG   = 2 ** RW;
    localparam logic [D-1:0]  DonePc = D'(DONE_PC);
    localparam logic [CW-1:0] CntMax = '1;

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StDone} state_e;

    state_e         state_q, state_d;
    logic [D-1:0]   pc_q;
    logic [8:0]     ir_q;
    logic [W-1:0]   regs_q [NREG];
    logic           dm_we_q;
    logic [W-1:0]   dm_addr_q, dm_wdata_q;
    logic [CW-1:0]  cnt_q;

    logic [2:0]     op;
    logic [RW-1:0]  ra, rb;
    logic [W-1:0]   va, vb, alu_res;
    logic [D-1:0]   br_off;
    logic           at_done_pc, is_halt, is_mem, go, active;

    assign op         = ir_q[8:6];
    assign ra         = ir_q[3 +: RW];
    assign rb         = ir_q[0 +: RW];
    assign va         = regs_q[ra];
    assign vb         = regs_q[rb];
    assign br_off     = {{(D-3){ir_q[2]}}, ir_q[2:0]};
    assign at_done_pc = (pc_q == DonePc);
    assign is_halt    = (op == 3'b111) && (ir_q[2:0] == 3'b000);
    assign is_mem     = (op == 3'b101) || (op == 3'b110);
    assign go         = start && ((state_q == StIdle) || (state_q == StDone));
    assign active     = (state_q == StFetch) || (state_q == StExec) || (state_q == StMem);

    always_comb begin
        case (op[1:0])
            2'b00:   alu_res = va + vb;
            2'b01:   alu_res = va - vb;
            2'b10:   alu_res = va & vb;
            default: alu_res = va ^ vb;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: begin
                if (at_done_pc)    state_d = StDone;
                else if (imem_ack) state_d = StExec;
            end
            StExec: begin
                if (is_mem)       state_d = StMem;
                else if (is_halt) state_d = StDone;
                else              state_d = StFetch;
            end
            StMem:   if (dmem_ack) state_d = StFetch;
            StDone:  if (start) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them asynchronously.
    always_comb begin
        imem_req   = (state_q == StFetch) && !at_done_pc;
        imem_addr  = pc_q;
        dmem_req   = (state_q == StMem);
        dmem_we    = (state_q == StMem) && dm_we_q;
        dmem_addr  = dm_addr_q;
        dmem_wdata = dm_wdata_q;
        done       = (state_q == StDone);
        cycle_cnt  = cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            ir_q       <= '0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: if (start) pc_q <= '0;
                StFetch: if (imem_ack && !at_done_pc) ir_q <= imem_data;
                StExec: begin
                    if (!op[2]) begin
                        regs_q[ra] <= alu_res;
                        pc_q       <= pc_q + D'(1);
                    end else begin
                        case (op[1:0])
                            2'b00: begin
                                regs_q[0] <= W'(ir_q[5:0]);
                                pc_q      <= pc_q + D'(1);
                            end
                            2'b01, 2'b10: begin
                                dm_we_q    <= op[1];
                                dm_addr_q  <= vb;
                                dm_wdata_q <= va;
                            end
                            default: begin
                                // b == 0 is HALT: PC stays put.
                                if (ir_q[2:0] != 3'b000) begin
                                    pc_q <= (va != '0) ? pc_q + br_off : pc_q + D'(1);
                                end
                            end
                        endcase
                    end
                end
                StMem: begin
                    if (dmem_ack) begin
                        if (!dm_we_q) regs_q[ra] <= dmem_rdata;
                        pc_q <= pc_q + D'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (go) begin
            cnt_q <= '0;
        end else if (active && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_mc_core.sv
// Bench for mc_core: bench-side memories with configurable wait states, and an
// instruction-level reference model that predicts registers, dmem, PC trace and cycles.
module tb_mc_core;

    localparam int D = 10;
    localparam int W = 8;
    localparam int DONE_PC = 354;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         imem_req, imem_ack = 1'b0;
    logic [D-1:0] imem_addr;
    logic [8:0]   imem_data = '0;
    logic         dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic         done;
    logic [15:0]  cycle_cnt;

    logic         imem_req4, dmem_req4, dmem_we4, done4;
    logic [D-1:0] imem_addr4;
    logic [W-1:0] dmem_addr4, dmem_wdata4;
    logic [3:0]   cycle_cnt4;

    mc_core #(.D(D), .W(W), .RW(3), .DONE_PC(DONE_PC), .CW(16)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .done(done), .cycle_cnt(cycle_cnt)
    );

    // Narrow-counter twin fed identical inputs; only its counter is of interest.
    mc_core #(.D(D), .W(W), .RW(3), .DONE_PC(DONE_PC), .CW(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req4), .imem_addr(imem_addr4), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_addr(dmem_addr4),
        .dmem_wdata(dmem_wdata4), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .done(done4),
        .cycle_cnt(cycle_cnt4)
    );

    always #5 clk = ~clk;

    logic [8:0]   imem [1024];
    logic [W-1:0] dmem [256];
    int           iw = 0, dw = 0, iwc = 0, dwc = 0;
    bit           stab_err = 0, both_err = 0, saw_done_fetch = 0;
    logic [D-1:0] ihold;
    logic [W-1:0] dahold, dwhold;
    logic         dwehold;
    int unsigned  trace[$];

    logic [W-1:0] m_regs [8];
    logic [W-1:0] m_dmem [256];
    int           m_cycles;
    int unsigned  m_trace[$];

    int checks = 0, errors = 0;

    // Memory responder: acks after iw/dw wait cycles, records fetches and stability.
    always @(negedge clk) begin
        if (!reset) begin
            imem_ack = 1'b0; dmem_ack = 1'b0; iwc = 0; dwc = 0;
        end else begin
            if (imem_req && dmem_req) both_err = 1;
            if (imem_req) begin
                if (imem_addr == D'(DONE_PC)) saw_done_fetch = 1;
                if (iwc == 0) ihold = imem_addr;
                else if (imem_addr !== ihold) stab_err = 1;
                if (iwc >= iw) begin
                    imem_ack = 1'b1; imem_data = imem[imem_addr];
                    trace.push_back(imem_addr); iwc = 0;
                end else begin
                    imem_ack = 1'b0; iwc++;
                end
            end else begin
                imem_ack = 1'b0; iwc = 0;
            end
            if (dmem_req) begin
                if (dwc == 0) begin
                    dahold = dmem_addr; dwhold = dmem_wdata; dwehold = dmem_we;
                end else if (dmem_addr !== dahold || dmem_wdata !== dwhold
                             || dmem_we !== dwehold) begin
                    stab_err = 1;
                end
                if (dwc >= dw) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = dmem[dmem_addr];
                    dwc = 0;
                end else begin
                    dmem_ack = 1'b0; dwc++;
                end
            end else begin
                dmem_ack = 1'b0; dwc = 0;
            end
        end
    end

    function automatic logic [8:0] ins(input int op, input int a, input int b);
        return 9'((op << 6) | (a << 3) | b);
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = ins(7, 0, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
    endtask

    // Instruction-level model: executes imem from PC 0 using the documented latencies.
    task automatic model_run();
        int pc, op, a, b, off, nxt;
        logic [8:0] w;
        pc = 0; m_cycles = 0; m_trace.delete();
        for (int i = 0; i < 256; i++) m_dmem[i] = dmem[i];
        for (int step = 0; step < 5000; step++) begin
            if (pc == DONE_PC) begin m_cycles += 1; break; end
            w = imem[pc];
            m_trace.push_back(pc);
            op = int'(w) >> 6; a = (int'(w) >> 3) & 7; b = int'(w) & 7;
            m_cycles += iw + 2;
            if (op == 7 && b == 0) break;
            nxt = (pc + 1) % 1024;
            case (op)
                0: m_regs[a] = m_regs[a] + m_regs[b];
                1: m_regs[a] = m_regs[a] - m_regs[b];
                2: m_regs[a] = m_regs[a] & m_regs[b];
                3: m_regs[a] = m_regs[a] ^ m_regs[b];
                4: m_regs[0] = W'(int'(w) & 63);
                5: begin m_regs[a] = m_dmem[m_regs[b]]; m_cycles += dw + 1; end
                6: begin m_dmem[m_regs[b]] = m_regs[a]; m_cycles += dw + 1; end
                default: begin
                    off = (b >= 4) ? b - 8 : b;
                    if (m_regs[a] != 0) nxt = (pc + off + 1024) % 1024;
                end
            endcase
            pc = nxt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic run(input int budget, output int n);
        @(negedge clk); start = 1'b1; trace.delete();
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req got=%b exp=0", dmem_req); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cycle_cnt); end
        checks++; if (imem_addr !== '0) begin errors++; $display("FAIL rst_pc got=%0d exp=0", imem_addr); end
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_quiet got req=%b done=%b exp=0/0", imem_req, done); end
    endtask

    task automatic test_basic();
        int n;
        do_reset(); iw = 0; dw = 0; clear_imem();
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        imem[0] = ins(4, 0, 5); imem[1] = ins(0, 1, 0); imem[2] = ins(0, 1, 0);
        model_run();
        run(100, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (n != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", n); end
        checks++; if (cycle_cnt !== 16'd8) begin errors++; $display("FAIL basic_cnt got=%0d exp=8", cycle_cnt); end
        checks++; if (int'(cycle_cnt) != m_cycles) begin errors++; $display("FAIL basic_cnt_model got=%0d exp=%0d", cycle_cnt, m_cycles); end
        // Registers survive a restart from DONE; dump R1 to observe it.
        clear_imem(); imem[0] = ins(6, 1, 2);
        model_run();
        run(100, n);
        checks++; if (dmem[0] !== 8'd10) begin errors++; $display("FAIL basic_r1 got=%0d exp=10", dmem[0]); end
        checks++; if (dmem[0] !== m_dmem[0]) begin errors++; $display("FAIL basic_r1_model got=%0d exp=%0d", dmem[0], m_dmem[0]); end
    endtask

    task automatic test_loop();
        int n;
        bit bad;
        do_reset(); iw = 1; dw = 0; clear_imem();
        imem[0] = ins(4, 0, 1); imem[1] = ins(0, 1, 0); imem[2] = ins(4, 0, 3);
        imem[3] = ins(1, 0, 1); imem[4] = ins(7, 0, 7);
        model_run();
        run(200, n);
        checks++; if (trace.size() != 10) begin errors++; $display("FAIL loop_trace_len got=%0d exp=10", trace.size()); end
        bad = (trace.size() != m_trace.size());
        for (int i = 0; i < trace.size() && !bad; i++) if (trace[i] != m_trace[i]) bad = 1;
        checks++; if (bad) begin errors++; $display("FAIL loop_trace got_len=%0d exp_len=%0d", trace.size(), m_trace.size()); end
        checks++; if (int'(cycle_cnt) != m_cycles) begin errors++; $display("FAIL loop_cnt got=%0d exp=%0d", cycle_cnt, m_cycles); end
        clear_imem(); imem[0] = ins(7, 1, 7);
        run(50, n);
        checks++; if (trace.size() != 2 || trace[trace.size()-1] != 1023) begin
            errors++; $display("FAIL loop_wrap got_len=%0d exp=2 last_exp=1023", trace.size());
        end
    endtask

    task automatic test_mem();
        int n;
        do_reset(); iw = 0; dw = 3; clear_imem(); stab_err = 0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
        imem[0] = ins(4, 5, 2); imem[1] = ins(0, 1, 0); imem[2] = ins(4, 0, 7);
        imem[3] = ins(6, 1, 0); imem[4] = ins(5, 2, 0); imem[5] = ins(4, 1, 0);
        imem[6] = ins(6, 2, 0);
        model_run();
        run(300, n);
        checks++; if (dmem[7] !== 8'd42) begin errors++; $display("FAIL mem_store got=%0d exp=42", dmem[7]); end
        checks++; if (dmem[8] !== 8'd42) begin errors++; $display("FAIL mem_load got=%0d exp=42", dmem[8]); end
        checks++; if (stab_err) begin errors++; $display("FAIL mem_stable got=1 exp=0"); end
        checks++; if (cycle_cnt !== 16'd28) begin errors++; $display("FAIL mem_cnt got=%0d exp=28", cycle_cnt); end
        checks++; if (int'(cycle_cnt) != m_cycles) begin errors++; $display("FAIL mem_cnt_model got=%0d exp=%0d", cycle_cnt, m_cycles); end
        clear_imem(); imem[0] = ins(5, 3, 0);
        run(100, n);
        checks++; if (cycle_cnt !== 16'd8) begin errors++; $display("FAIL mem_ld_latency got=%0d exp=8 (6+halt)", cycle_cnt); end
    endtask

    task automatic test_done_pc();
        int n;
        do_reset(); iw = 0; dw = 0; clear_imem(); saw_done_fetch = 0;
        for (int i = 0; i < DONE_PC; i++) imem[i] = ins(4, (i >> 3) & 7, i & 7);
        imem[DONE_PC] = ins(4, 0, 1);
        run(1000, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL donepc_done got=%b exp=1", done); end
        checks++; if (saw_done_fetch) begin errors++; $display("FAIL donepc_req got=1 exp=0"); end
        checks++; if (trace.size() != DONE_PC || trace[trace.size()-1] != DONE_PC - 1) begin
            errors++; $display("FAIL donepc_trace got_len=%0d exp=%0d", trace.size(), DONE_PC);
        end
        checks++; if (cycle_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got=%0d exp=15", cycle_cnt4); end
    endtask

    task automatic test_saturate();
        int n;
        clear_imem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (cycle_cnt4 !== 4'd0 || done !== 1'b0) begin
            errors++; $display("FAIL restart_clear got cnt=%0d done=%b exp=0/0", cycle_cnt4, done);
        end
        for (int i = 0; i < 10; i++) imem[i] = ins(4, 0, i);
        run(200, n);
        checks++; if (cycle_cnt !== 16'd22) begin errors++; $display("FAIL sat_cnt16 got=%0d exp=22", cycle_cnt); end
        checks++; if (cycle_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4_b got=%0d exp=15", cycle_cnt4); end
    endtask

    task automatic test_reset_mid_mem();
        int n;
        bit seen;
        do_reset(); iw = 0; dw = 50; clear_imem();
        imem[0] = ins(4, 1, 1); imem[1] = ins(6, 0, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = dmem_req; end
        checks++; if (!seen) begin errors++; $display("FAIL midmem_req_seen got=0 exp=1"); end
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL midmem_drop got=%b exp=0", dmem_req); end
        checks++; if (done !== 1'b0 || imem_addr !== '0 || cycle_cnt !== '0) begin
            errors++; $display("FAIL midmem_clear got done=%b pc=%0d cnt=%0d exp=0/0/0", done, imem_addr, cycle_cnt);
        end
        @(negedge clk); reset = 1'b1; model_reset();
        dw = 0; dmem[0] = 8'hAA; clear_imem(); imem[0] = ins(6, 3, 0);
        model_run();
        run(100, n);
        checks++; if (trace.size() == 0 || trace[0] != 0) begin errors++; $display("FAIL midmem_pc0 got_len=%0d exp first=0", trace.size()); end
        checks++; if (dmem[0] !== m_dmem[0]) begin errors++; $display("FAIL midmem_regs got=%0h exp=%0h", dmem[0], m_dmem[0]); end
        checks++; if (cycle_cnt !== 16'd5) begin errors++; $display("FAIL midmem_cnt got=%0d exp=5", cycle_cnt); end
    endtask

    task automatic test_random();
        int n, pc, bad_at;
        bit bad;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            iw = $urandom_range(0, 2); dw = $urandom_range(0, 2); stab_err = 0;
            for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
            clear_imem();
            pc = 0;
            for (int i = 0; i < 14; i++) begin
                imem[pc] = ins($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7));
                pc++;
            end
            for (int r = 1; r < 8; r++) begin
                imem[pc] = ins(4, 6, r); imem[pc+1] = ins(6, r, 0); pc += 2;
            end
            model_run();
            run(2000, n);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done got=%b exp=1", it, done); end
            checks++; if (int'(cycle_cnt) != m_cycles) begin errors++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", it, cycle_cnt, m_cycles); end
            bad = 0; bad_at = 0;
            for (int i = 0; i < 256 && !bad; i++) if (dmem[i] !== m_dmem[i]) begin bad = 1; bad_at = i; end
            checks++; if (bad) begin errors++; $display("FAIL rnd%0d_dmem at=%0d got=%0h exp=%0h", it, bad_at, dmem[bad_at], m_dmem[bad_at]); end
            bad = (trace.size() != m_trace.size()) || stab_err;
            for (int i = 0; i < trace.size() && !bad; i++) if (trace[i] != m_trace[i]) bad = 1;
            checks++; if (bad) begin errors++; $display("FAIL rnd%0d_trace got_len=%0d exp_len=%0d stab=%0d", it, trace.size(), m_trace.size(), stab_err); end
        end
    endtask

    initial begin
        clear_imem();
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        test_reset();
        test_basic();
        test_loop();
        test_mem();
        test_done_pc();
        test_saturate();
        test_reset_mid_mem();
        test_random();
        checks++; if (both_err) begin errors++; $display("FAIL exclusive_req got=1 exp=0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
